// File: rtl/alu4_sequencer_if.sv
// Host command bus for alu4_sequencer.
// Ports (signals):
//   start, cmd, opa, opb                  host -> sequencer command strobe and operands
//   busy, done, result, carry_out,
//   overflow, zero                        sequencer -> host status and registered result
// Modports: master = host side, slave = sequencer side.
interface alu4_sequencer_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [1:0]           cmd;
  logic [2*WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0]   opb;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 carry_out;
  logic                 overflow;
  logic                 zero;

  modport master (
    output start, cmd, opa, opb,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, cmd, opa, opb,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/alu4_sequencer.sv
// Initiator for a combinational alu4: runs 8-bit ADD/SUB/CMP as two chained
// nibble steps and a 4x4 MUL as WIDTH shift-add steps, one ALU step per clock.
// Ports:
//   clk, rst_n (sync, active low), ena (0 = everything holds)
//   host          command bus (slave modport): start/cmd/opa/opb in,
//                 busy/done/result/carry_out/overflow/zero out
//   alu_a/alu_b/alu_y/alu_b_zero/alu_b_inv/alu_b_lsr/alu_op   ALU drive
//   alu_s/alu_c/alu_zero/alu_overflow                         ALU response
module alu4_sequencer #(
  parameter int                     WIDTH    = 4,
  parameter int                     OP_WIDTH = 2,
  parameter logic [OP_WIDTH-1:0]    OP_ADD   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  alu4_sequencer_if.slave      host,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_y,
  output logic                 alu_b_zero,
  output logic                 alu_b_inv,
  output logic                 alu_b_lsr,
  output logic [OP_WIDTH-1:0]  alu_op,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_c,
  input  logic                 alu_zero,
  input  logic                 alu_overflow
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_SUB = 2'b01, CMD_MUL = 2'b10, CMD_CMP = 2'b11} cmd_t;

  state_t            r_state;
  cmd_t              r_cmd;
  logic [DW-1:0]     r_opa;
  logic [DW-1:0]     r_opb;
  logic [WIDTH-1:0]  r_lo_s;
  logic              r_cy;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_mq;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_result;
  logic              r_carry;
  logic              r_ovf;
  logic              r_zero;
  logic              r_busy;
  logic              r_done;

  logic              w_sub;
  logic [WIDTH-1:0]  w_acc_nx;
  logic [WIDTH-1:0]  w_mq_nx;

  // SUB and CMP both compute A + ~B + 1
  assign w_sub = (r_cmd == CMD_SUB) || (r_cmd == CMD_CMP);

  // One shift-add step: {carry, sum} shifts right into acc, sum LSB enters mq top
  assign w_acc_nx = {alu_c, alu_s[WIDTH-1:1]};
  assign w_mq_nx  = {alu_s[0], r_mq[WIDTH-1:1]};

  assign alu_b_lsr = 1'b0;
  assign alu_op    = OP_ADD;

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_y      = 1'b0;
    alu_b_zero = 1'b0;
    alu_b_inv  = 1'b0;
    case (r_state)
      S_LO: begin
        alu_a     = r_opa[WIDTH-1:0];
        alu_b     = r_opb[WIDTH-1:0];
        alu_b_inv = w_sub;
        alu_y     = w_sub;
      end
      S_HI: begin
        alu_a     = r_opa[DW-1:WIDTH];
        alu_b     = r_opb[DW-1:WIDTH];
        alu_b_inv = w_sub;
        alu_y     = r_cy;
      end
      S_MUL: begin
        alu_a      = r_acc;
        alu_b      = r_opa[WIDTH-1:0];
        alu_b_zero = ~r_mq[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cmd    <= CMD_ADD;
      r_opa    <= '0;
      r_opb    <= '0;
      r_lo_s   <= '0;
      r_cy     <= 1'b0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (host.start) begin
            r_cmd  <= cmd_t'(host.cmd);
            r_opa  <= host.opa;
            r_opb  <= host.opb;
            r_busy <= 1'b1;
            if (cmd_t'(host.cmd) == CMD_MUL) begin
              r_acc   <= '0;
              r_mq    <= host.opb[WIDTH-1:0];
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else begin
              r_state <= S_LO;
            end
          end
        end
        S_LO: begin
          r_lo_s  <= alu_s;
          r_cy    <= alu_c;
          r_state <= S_HI;
        end
        S_HI: begin
          r_carry <= alu_c;
          r_ovf   <= alu_overflow;
          r_zero  <= (r_lo_s == '0) && alu_zero;
          if (r_cmd != CMD_CMP)
            r_result <= {alu_s, r_lo_s};
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_MUL: begin
          r_acc <= w_acc_nx;
          r_mq  <= w_mq_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result <= {w_acc_nx, w_mq_nx};
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= ({w_acc_nx, w_mq_nx} == '0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host.busy      = r_busy;
  assign host.done      = r_done;
  assign host.result    = r_result;
  assign host.carry_out = r_carry;
  assign host.overflow  = r_ovf;
  assign host.zero      = r_zero;

endmodule

// File: tb/tb_alu4_sequencer.sv
module tb_alu4_sequencer;

  localparam logic [1:0] C_ADD = 2'b00;
  localparam logic [1:0] C_SUB = 2'b01;
  localparam logic [1:0] C_MUL = 2'b10;
  localparam logic [1:0] C_CMP = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] alu_a, alu_b, alu_s;
  logic       alu_y, alu_b_zero, alu_b_inv, alu_b_lsr;
  logic [1:0] alu_op;
  logic       alu_c, alu_zero, alu_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_prev;

  alu4_sequencer_if #(.WIDTH(4)) bus ();

  alu4_sequencer #(.WIDTH(4), .OP_WIDTH(2), .OP_ADD(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .host(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_b_zero(alu_b_zero),
    .alu_b_inv(alu_b_inv), .alu_b_lsr(alu_b_lsr), .alu_op(alu_op),
    .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // Combinational alu4 stand-in (add path only)
  logic [3:0] bb;
  logic [4:0] sum;
  always_comb begin
    bb = alu_b_zero ? 4'h0 : alu_b;
    if (alu_b_inv) bb = ~bb;
    sum          = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_y};
    alu_s        = sum[3:0];
    alu_c        = sum[4];
    alu_zero     = (sum[3:0] == 4'h0);
    alu_overflow = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 8-bit reference arithmetic straight from the command definitions
  task automatic ref_model(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] prev, output logic [7:0] r,
                           output logic cy, output logic ov, output logic z);
    int sa, sb, sr, u;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      C_ADD: begin
        u = int'(a) + int'(b);  sr = sa + sb;
        r = u[7:0]; cy = (u > 255); ov = (sr > 127) || (sr < -128); z = (u[7:0] == 8'h00);
      end
      C_MUL: begin
        u = int'(a[3:0]) * int'(b[3:0]);
        r = u[7:0]; cy = 1'b0; ov = 1'b0; z = (u == 0);
      end
      default: begin
        u = int'(a) - int'(b);  sr = sa - sb;
        cy = (a >= b); ov = (sr > 127) || (sr < -128); z = (u[7:0] == 8'h00);
        r = (c == C_CMP) ? prev : u[7:0];
      end
    endcase
  endtask

  // Issue one command from IDLE and check timing, ALU drive and results
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
    int edges;
    int exp_lat;
    logic [7:0] r;
    logic cy, ov, z;
    exp_lat = (c == C_MUL) ? 4 : 2;
    bus.start = 1'b1; bus.cmd = c; bus.opa = a; bus.opb = b;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    edges = 0;
    while (!bus.done && edges < 10) begin
      if (c == C_MUL && edges < 4)
        chk("mul_b_zero", alu_b_zero, {31'b0, ~b[edges]});
      if (c != C_MUL && edges == 0) begin
        chk("lo_alu_a", alu_a, a[3:0]);
        chk("lo_b_inv", alu_b_inv, (c == C_SUB || c == C_CMP));
      end
      tick();
      edges++;
    end
    chk("latency", edges, exp_lat);
    ref_model(c, a, b, exp_prev, r, cy, ov, z);
    exp_prev = r;
    chk("done", bus.done, 1);
    chk("result", bus.result, r);
    chk("carry_out", bus.carry_out, cy);
    chk("overflow", bus.overflow, ov);
    chk("zero", bus.zero, z);
    tick();
    chk("done_pulse_end", bus.done, 0);
    chk("busy_end", bus.busy, 0);
  endtask

  initial begin
    int dones, edges;
    logic [7:0] r;
    logic cy, ov, z;

    rst_n = 1'b0; ena = 1'b1;
    bus.start = 1'b0; bus.cmd = 2'b00; bus.opa = 8'h00; bus.opb = 8'h00;
    exp_prev = 8'h00;
    tick(); tick();
    chk("rst_result", bus.result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flags", {bus.carry_out, bus.overflow, bus.zero}, 0);
    chk("rst_alu_drive", {alu_a, alu_b, alu_y, alu_b_zero, alu_b_inv}, 0);
    chk("alu_b_lsr", alu_b_lsr, 0);
    chk("alu_op", alu_op, 0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_cmd(C_ADD, 8'h3C, 8'h47);
    run_cmd(C_SUB, 8'h50, 8'h50);
    run_cmd(C_SUB, 8'h10, 8'h20);
    run_cmd(C_MUL, 8'h0F, 8'h0F);
    run_cmd(C_MUL, 8'h00, 8'h09);
    run_cmd(C_ADD, 8'h3C, 8'h47);
    run_cmd(C_CMP, 8'h80, 8'h01);
    chk("cmp_keeps_result", bus.result, 8'h83);

    // start held high through a MUL4: one done, re-accept only from IDLE
    bus.start = 1'b1; bus.cmd = C_MUL; bus.opa = 8'h03; bus.opb = 8'h05;
    tick();
    dones = 0; edges = 0;
    while (!bus.done && edges < 10) begin tick(); edges++; end
    if (bus.done) dones++;
    chk("held_latency", edges, 4);
    chk("held_result", bus.result, 8'h0F);
    tick();
    chk("held_ignored_in_done", bus.busy, 0);
    chk("held_no_second_done", bus.done, 0);
    tick();
    chk("held_accept_from_idle", bus.busy, 1);
    bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 10) begin tick(); edges++; end
    if (bus.done) dones++;
    chk("held_done_count", dones, 2);
    tick();
    exp_prev = 8'h0F;

    // Reset during MUL with cnt == 2
    bus.start = 1'b1; bus.cmd = C_MUL; bus.opa = 8'h07; bus.opb = 8'h06;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_outputs", {bus.done, bus.carry_out, bus.overflow, bus.zero}, 0);
    chk("abort_result", bus.result, 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (bus.done) dones++; end
    chk("abort_no_done", dones, 0);
    exp_prev = 8'h00;

    // ena low while in HI, then while in DONE
    ref_model(C_ADD, 8'h9A, 8'h7B, exp_prev, r, cy, ov, z);
    bus.start = 1'b1; bus.cmd = C_ADD; bus.opa = 8'h9A; bus.opb = 8'h7B;
    tick();
    bus.start = 1'b0;
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_busy", bus.busy, 1);
      chk("frz_done", bus.done, 0);
      chk("frz_alu_ab", {alu_a, alu_b}, 8'h97);
    end
    ena = 1'b1;
    tick();
    chk("frz_release_done", bus.done, 1);
    chk("frz_result", bus.result, r);
    chk("frz_carry", bus.carry_out, cy);
    chk("frz_ovf", bus.overflow, ov);
    ena = 1'b0;
    tick(); tick();
    chk("frz_done_held", bus.done, 1);
    ena = 1'b1;
    tick();
    chk("frz_done_cleared", bus.done, 0);
    exp_prev = r;

    // Random commands
    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom_range(3)), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
